ex_mem_elastic: RTL and testbench

- Parametrised EX/MEM pipeline boundary for the RISC-V core; replaces the bare always-capture register with an elastic stage.
- Carries the execute-stage payload: rs_1, rs_2, rd_num, alu_out, opcode, func_3, op_type.
- Adds a valid/ready handshake, a 2-entry skid buffer so MEM back-pressure never combinationally reaches EX, a synchronous flush, and destination masking for invalid slots.

---
 rtl/ex_mem_elastic.sv | 144 ++++++++++++++
 tb/tb_ex_mem_elastic.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_elastic
//  Purpose  : Elastic EX/MEM pipeline boundary. Carries the execute-stage
//             payload behind a valid/ready handshake with a 2-entry skid
//             buffer, so MEM back-pressure never reaches EX combinationally.
//             Supports a synchronous flush and optional masking of the
//             destination index for invalid slots.
//  Ports    : clk, rst_n (async active-low)
//             i_valid / o_ready          - upstream (EX) handshake
//             i_rs_1 .. i_op_type        - execute-stage payload in
//             i_flush                    - kill all held entries
//             o_valid / i_ready          - downstream (MEM) handshake
//             o_rs_1 .. o_op_type        - main-entry payload out
//             o_count                    - occupancy 0..2
//  Revision : 1.0 - initial elastic stage
// ============================================================================
module ex_mem_elastic #(
    parameter int XLEN            = 32,
    parameter int REG_W           = 5,
    parameter int MASK_INVALID_RD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_rs_1,
    input  logic [XLEN-1:0]  i_rs_2,
    input  logic [REG_W-1:0] i_rd_num,
    input  logic [XLEN-1:0]  i_alu_out,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_func_3,
    input  logic             i_op_type,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_rs_1,
    output logic [XLEN-1:0]  o_rs_2,
    output logic [REG_W-1:0] o_rd_num,
    output logic [XLEN-1:0]  o_alu_out,
    output logic [6:0]       o_opcode,
    output logic [2:0]       o_func_3,
    output logic             o_op_type,
    output logic [1:0]       o_count
);

    localparam int C_PW = 3 * XLEN + REG_W + 11;

    // Encoding is {skid_valid, main_valid} so the valid bits fall out directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [C_PW-1:0]   r_main;
    logic [C_PW-1:0]   r_skid;
    logic [C_PW-1:0]   w_in_pl;
    logic [REG_W-1:0]  w_rd_main;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;

    assign w_in_pl = {i_rs_1, i_rs_2, i_alu_out, i_rd_num, i_opcode, i_func_3, i_op_type};

    // Handshake outputs come straight from state flops: no i_ready -> o_ready path.
    assign o_valid = r_state[0];
    assign o_ready = ~r_state[1];
    assign o_count = {r_state[1], r_state[0] & ~r_state[1]};

    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = o_valid & i_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            // Flush wins over everything, including a same-cycle accept.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : w_in_pl;
            end
            if (w_load_skid) begin
                r_skid <= w_in_pl;
            end
        end
    end

    assign {o_rs_1, o_rs_2, o_alu_out, w_rd_main, o_opcode, o_func_3, o_op_type} = r_main;

    // A bubble must never look like a write to a real register for hazard logic.
    generate
        if (MASK_INVALID_RD != 0) begin : g_mask_rd
            assign o_rd_num = o_valid ? w_rd_main : '0;
        end else begin : g_raw_rd
            assign o_rd_num = w_rd_main;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_elastic
//  Purpose  : Self-checking bench for ex_mem_elastic (XLEN=64). Accepted
//             inputs are queued as expected outputs; a monitor pops and
//             compares on every output transfer.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_ex_mem_elastic;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XLEN-1:0]  alu;
        logic [REG_W-1:0] rd;
        logic [6:0]       op;
        logic [2:0]       f3;
        logic             t;
    } pl_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [XLEN-1:0]  i_rs_1 = '0;
    logic [XLEN-1:0]  i_rs_2 = '0;
    logic [REG_W-1:0] i_rd_num = '0;
    logic [XLEN-1:0]  i_alu_out = '0;
    logic [6:0]       i_opcode = '0;
    logic [2:0]       i_func_3 = '0;
    logic             i_op_type = 1'b0;
    logic             i_flush = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [XLEN-1:0]  o_rs_1;
    logic [XLEN-1:0]  o_rs_2;
    logic [REG_W-1:0] o_rd_num;
    logic [XLEN-1:0]  o_alu_out;
    logic [6:0]       o_opcode;
    logic [2:0]       o_func_3;
    logic             o_op_type;
    logic [1:0]       o_count;

    int  total = 0;
    int  bad   = 0;
    pl_t exp_q[$];
    bit  chk_count = 1'b0;

    ex_mem_elastic #(.XLEN(XLEN), .REG_W(REG_W), .MASK_INVALID_RD(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_rs_1(i_rs_1), .i_rs_2(i_rs_2), .i_rd_num(i_rd_num),
        .i_alu_out(i_alu_out), .i_opcode(i_opcode), .i_func_3(i_func_3),
        .i_op_type(i_op_type), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_rs_1(o_rs_1), .o_rs_2(o_rs_2), .o_rd_num(o_rd_num),
        .o_alu_out(o_alu_out), .o_opcode(o_opcode), .o_func_3(o_func_3),
        .o_op_type(o_op_type), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic pl_t mk(input logic [XLEN-1:0] alu);
        pl_t p;
        p.rs1 = alu + 64'd1;
        p.rs2 = ~alu;
        p.alu = alu;
        p.rd  = alu[4:0] | 5'd1;
        p.op  = 7'h33;
        p.f3  = alu[2:0];
        p.t   = alu[0];
        return p;
    endfunction

    task automatic drive(input pl_t p);
        i_rs_1 = p.rs1; i_rs_2 = p.rs2; i_alu_out = p.alu; i_rd_num = p.rd;
        i_opcode = p.op; i_func_3 = p.f3; i_op_type = p.t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard producer: record every accepted input; flush drops all.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_flush) exp_q.delete();
            else if (i_valid && o_ready)
                exp_q.push_back('{i_rs_1, i_rs_2, i_alu_out, i_rd_num, i_opcode, i_func_3, i_op_type});
        end
    end

    // Monitor: compare every output transfer against the queue head.
    always @(negedge clk) begin
        pl_t e;
        pl_t a;
        if (rst_n) begin
            if (chk_count) check("count_le_2", {126'd0, o_count != 2'd3}, 128'd1);
            if (o_valid && i_ready) begin
                a = '{o_rs_1, o_rs_2, o_alu_out, o_rd_num, o_opcode, o_func_3, o_op_type};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got alu 0x%0h required no output", o_alu_out);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL sb_payload: got alu 0x%0h rd %0d required alu 0x%0h rd %0d",
                                 a.alu, a.rd, e.alu, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        pl_t p;
        bit  rdy_before;

        // ---- reset then stream
        repeat (3) step();
        check("rst_valid", {127'd0, o_valid}, 128'd0);
        check("rst_count", {126'd0, o_count}, 128'd0);
        check("rst_ready", {127'd0, o_ready}, 128'd1);
        check("rst_alu",   {64'd0, o_alu_out}, 128'd0);
        check("rst_rd",    {123'd0, o_rd_num}, 128'd0);
        rst_n = 1'b1;
        step();
        i_ready = 1'b1; i_valid = 1'b1;
        drive(mk(64'h10)); step();
        check("stream_v1",   {127'd0, o_valid}, 128'd1);
        check("stream_a1",   {64'd0, o_alu_out}, 128'h10);
        check("stream_c1",   {126'd0, o_count}, 128'd1);
        drive(mk(64'h20)); step();
        check("stream_a2",   {64'd0, o_alu_out}, 128'h20);
        check("stream_c2",   {126'd0, o_count}, 128'd1);
        drive(mk(64'h30)); step();
        check("stream_a3",   {64'd0, o_alu_out}, 128'h30);
        check("stream_c3",   {126'd0, o_count}, 128'd1);
        i_valid = 1'b0; step();
        check("stream_drain", {127'd0, o_valid}, 128'd0);

        // ---- back-pressure
        i_ready = 1'b0; i_valid = 1'b1;
        drive(mk(64'hA)); step();
        check("bp_one", {126'd0, o_count}, 128'd1);
        drive(mk(64'hB)); step();
        check("bp_full_cnt", {126'd0, o_count}, 128'd2);
        check("bp_full_rdy", {127'd0, o_ready}, 128'd0);
        drive(mk(64'hC)); step();
        check("bp_hold_cnt", {126'd0, o_count}, 128'd2);
        check("bp_hold_alu", {64'd0, o_alu_out}, 128'hA);
        i_ready = 1'b1; step();
        check("bp_out_b", {64'd0, o_alu_out}, 128'hB);
        step();
        check("bp_out_c", {64'd0, o_alu_out}, 128'hC);
        i_valid = 1'b0; step();
        check("bp_empty", {126'd0, o_count}, 128'd0);

        // ---- flush in FULL
        i_ready = 1'b0; i_valid = 1'b1;
        drive(mk(64'h1)); step();
        drive(mk(64'h2)); step();
        check("fl_full", {126'd0, o_count}, 128'd2);
        i_flush = 1'b1; drive(mk(64'hD)); step();
        i_flush = 1'b0; i_valid = 1'b0;
        check("fl_valid", {127'd0, o_valid}, 128'd0);
        check("fl_count", {126'd0, o_count}, 128'd0);
        check("fl_ready", {127'd0, o_ready}, 128'd1);
        check("fl_rd",    {123'd0, o_rd_num}, 128'd0);
        i_ready = 1'b1; step(); step();
        check("fl_no_d", {127'd0, o_valid}, 128'd0);

        // ---- field integrity and bubble masking
        p = '{64'h123, 64'hDEADBEEF, 64'h1000, 5'd7, 7'h23, 3'b101, 1'b1};
        drive(p); i_valid = 1'b1; step();
        check("fi_rs2", {64'd0, o_rs_2}, 128'hDEADBEEF);
        check("fi_rd",  {123'd0, o_rd_num}, 128'd7);
        check("fi_op",  {121'd0, o_opcode}, 128'h23);
        check("fi_f3",  {125'd0, o_func_3}, 128'd5);
        check("fi_t",   {127'd0, o_op_type}, 128'd1);
        i_valid = 1'b0; step();
        check("bub_valid", {127'd0, o_valid}, 128'd0);
        check("bub_rd",    {123'd0, o_rd_num}, 128'd0);
        check("bub_f3",    {125'd0, o_func_3}, 128'd5);

        // ---- async reset in FULL
        i_ready = 1'b0; i_valid = 1'b1;
        drive(mk(64'h44)); step();
        drive(mk(64'h55)); step();
        i_valid = 1'b0;
        check("ar_full", {126'd0, o_count}, 128'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("ar_valid", {127'd0, o_valid}, 128'd0);
        check("ar_count", {126'd0, o_count}, 128'd0);
        check("ar_ready", {127'd0, o_ready}, 128'd1);
        step();
        rst_n = 1'b1;
        step();

        // ---- random valid/ready
        chk_count = 1'b1;
        p = mk({$urandom, $urandom});
        for (int i = 0; i < 10000; i++) begin
            i_valid = ($urandom_range(0, 2) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 99) == 0);
            if (i_flush) i_ready = 1'b0;
            drive(p);
            rdy_before = o_ready;
            step();
            // Upstream holds an unaccepted payload; otherwise present a new one.
            if (!(i_valid && !rdy_before && !i_flush)) p = mk({$urandom, $urandom});
        end
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        repeat (4) step();
        chk_count = 1'b0;
        check("drain_q", {96'd0, exp_q.size()}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
